prbs_sync_checker: RTL

//  Parametrised successor to the fixed PRBS31 bit-error counter. Checks a W-bit-per-cycle

---
 rtl/prbs_pkg.sv | 39 +++
 rtl/prbs_predict.sv | 34 +++
 rtl/prbs_sync_checker.sv | 121 ++++++++++++
 3 files changed

// File: rtl/prbs_pkg.sv
// Shared PRBS definitions: tap table, FSM states and small arithmetic helpers
// used by the sync checker and the PRBS generator.
package prbs_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } lock_state_e;

    // Second feedback tap; the first tap is always the polynomial order itself.
    function automatic int prbs_tap2(input int order);
        case (order)
            7:       return 6;
            15:      return 14;
            23:      return 18;
            default: return 28;
        endcase
    endfunction

    function automatic logic [6:0] popcount64(input logic [63:0] v);
        logic [6:0] c;
        c = '0;
        for (int i = 0; i < 64; i++) begin
            c = c + {6'd0, v[i]};
        end
        return c;
    endfunction

    function automatic logic [63:0] sat_add64(input logic [63:0] a, input logic [63:0] b);
        logic [64:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[64] ? '1 : s[63:0];
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] a);
        return (a == '1) ? a : a + 16'd1;
    endfunction

endpackage

// File: rtl/prbs_predict.sv
// Combinational self-synchronising PRBS predictor: expected word and bit-error
// vector from the received history and the current word, plus the advanced history.
module prbs_predict
    import prbs_pkg::*;
#(
    parameter int W      = 32,
    parameter int PRBS_N = 31,
    parameter bit INVERT = 1'b0
) (
    input  logic [PRBS_N-1:0] hist,
    input  logic [W-1:0]      data_in,
    output logic [W-1:0]      bit_err,
    output logic [PRBS_N-1:0] next_hist
);

    localparam int TAP2 = prbs_tap2(PRBS_N);

    // ext[i+k] is the bit received k bit-times before data_in[i], whether it
    // lies in this word or in the history.
    logic [PRBS_N+W-1:0] ext;
    logic [W-1:0]        expected;

    assign ext = {hist, data_in};

    always_comb begin
        for (int i = 0; i < W; i++) begin
            expected[i] = ext[i+PRBS_N] ^ ext[i+TAP2] ^ INVERT;
        end
    end

    assign bit_err   = expected ^ data_in;
    assign next_hist = ext[PRBS_N-1:0];

endmodule

// File: rtl/prbs_sync_checker.sv
// Self-synchronising PRBS bit-error checker with HUNT/LOCKED tracking and
// saturating error, word and lock-loss counters.
module prbs_sync_checker
    import prbs_pkg::*;
#(
    parameter int W          = 32,
    parameter int PRBS_N     = 31,
    parameter bit INVERT     = 1'b0,
    parameter int LOCK_CNT   = 16,
    parameter int BAD_THRESH = 4,
    parameter int UNLOCK_CNT = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   data_valid,
    input  logic [W-1:0]           data_in,
    output logic                   locked,
    output logic [63:0]            err_count,
    output logic [63:0]            word_count,
    output logic [15:0]            lock_loss,
    output logic [$clog2(W+1)-1:0] word_err
);

    localparam int WE = $clog2(W+1);
    localparam int GW = $clog2(LOCK_CNT+1);
    localparam int BW = $clog2(UNLOCK_CNT+1);

    logic [PRBS_N-1:0] hist, next_hist;
    logic [W-1:0]      bit_err, err1;
    logic              v1;
    logic [WE-1:0]     werr2;
    lock_state_e       state, state_nxt;
    logic [GW-1:0]     good_run, good_nxt;
    logic [BW-1:0]     bad_run, bad_nxt;
    logic              count_en, loss_inc;

    prbs_predict #(.W(W), .PRBS_N(PRBS_N), .INVERT(INVERT)) u_predict (
        .hist      (hist),
        .data_in   (data_in),
        .bit_err   (bit_err),
        .next_hist (next_hist)
    );

    assign werr2  = WE'(popcount64(64'(err1)));
    assign locked = (state == LOCKED);

    always_comb begin
        // NOTE: defaults first so every path assigns every signal; otherwise a latch is inferred.
        state_nxt = state;
        good_nxt  = good_run;
        bad_nxt   = bad_run;
        count_en  = 1'b0;
        loss_inc  = 1'b0;
        if (v1) begin
            unique case (state)
                HUNT: begin
                    if (werr2 != '0) begin
                        good_nxt = '0;
                    end else if (good_run == GW'(LOCK_CNT-1)) begin
                        state_nxt = LOCKED;
                        good_nxt  = '0;
                        bad_nxt   = '0;
                    end else begin
                        good_nxt = good_run + GW'(1);
                    end
                end
                LOCKED: begin
                    count_en = 1'b1;
                    if (werr2 < WE'(BAD_THRESH)) begin
                        bad_nxt = '0;
                    end else if (bad_run == BW'(UNLOCK_CNT-1)) begin
                        state_nxt = HUNT;
                        loss_inc  = 1'b1;
                        good_nxt  = '0;
                        bad_nxt   = '0;
                    end else begin
                        bad_nxt = bad_run + BW'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: non-blocking so every register samples pre-edge values of the others.
        if (reset) begin
            hist       <= '0;
            err1       <= '0;
            v1         <= 1'b0;
            state      <= HUNT;
            good_run   <= '0;
            bad_run    <= '0;
            word_err   <= '0;
            err_count  <= '0;
            word_count <= '0;
            lock_loss  <= '0;
        end else begin
            if (data_valid) hist <= next_hist;
            err1     <= bit_err;
            v1       <= data_valid;
            state    <= state_nxt;
            good_run <= good_nxt;
            bad_run  <= bad_nxt;
            if (v1) word_err <= werr2;
            // Clear wins over an increment landing on the same edge.
            if (clear) begin
                err_count  <= '0;
                word_count <= '0;
                lock_loss  <= '0;
            end else begin
                if (count_en) begin
                    err_count  <= sat_add64(err_count, 64'(werr2));
                    word_count <= sat_add64(word_count, 64'd1);
                end
                if (loss_inc) lock_loss <= sat_inc16(lock_loss);
            end
        end
    end

endmodule
